// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - control, RAM read port and output stream bundle for ram_stream_reader
// master is the reader's view; slave is the view of whatever drives and consumes it.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;

  logic                  ram_clken;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_read_en;
  logic                  ram_write_en;
  logic [DATA_WIDTH-1:0] ram_read_data;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    input  start, base_addr, length, ram_read_data, out_ready,
    output busy, done, ram_clken, ram_address, ram_read_en, ram_write_en,
           out_data, out_valid, out_last
  );

  modport slave (
    output start, base_addr, length, ram_read_data, out_ready,
    input  busy, done, ram_clken, ram_address, ram_read_en, ram_write_en,
           out_data, out_valid, out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a block of RAM words out over a valid/ready port
// Reads are issued against a credit count so the output FIFO can never overflow.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  ram_stream_reader_if.master bus
);
  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [LATENCY-1:0]    r_tag_vld;
  logic [LATENCY-1:0]    r_tag_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_credits;
  logic                  r_zero_done;

  logic w_start_ok;
  logic w_start_zero;
  logic w_issue;
  logic w_issue_last;
  logic w_push;
  logic w_pop;
  logic w_not_empty;
  logic w_head_last;
  logic w_last_beat;

  assign w_start_ok   = (r_state == IDLE) && bus.start && (bus.length != '0);
  assign w_start_zero = (r_state == IDLE) && bus.start && (bus.length == '0);
  // Credits cover reads in flight plus words already buffered.
  assign w_issue      = (r_state == ISSUE) && (r_credits < DEPTH_C);
  assign w_issue_last = w_issue && (r_remaining == (ADDR_WIDTH+1)'(1));
  assign w_push       = r_tag_vld[LATENCY-1];
  assign w_not_empty  = (r_count != '0);
  assign w_pop        = w_not_empty && bus.out_ready;
  assign w_head_last  = r_fifo_last[r_rd_ptr];
  assign w_last_beat  = w_pop && w_head_last;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_ok)   w_state_nxt = ISSUE;
      ISSUE:   if (w_issue_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_beat)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_tag_vld   <= '0;
      r_tag_last  <= '0;
      r_fifo_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_credits   <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_done <= w_start_zero;

      if (w_start_ok) begin
        r_addr      <= bus.base_addr;
        r_remaining <= bus.length;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
      end

      r_tag_vld[0]  <= w_issue;
      r_tag_last[0] <= w_issue_last;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end

      if (w_push) begin
        r_fifo_last[r_wr_ptr] <= r_tag_last[LATENCY-1];
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // A credit returns only when the word leaves the FIFO, so it is usable next cycle.
      unique case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.ram_read_data;
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_zero_done || ((r_state == DRAIN) && w_last_beat);
  assign bus.ram_clken    = 1'b1;
  assign bus.ram_write_en = 1'b0;
  assign bus.ram_read_en  = w_issue;
  assign bus.ram_address  = r_addr;
  assign bus.out_valid    = w_not_empty;
  assign bus.out_data     = w_not_empty ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.out_last     = w_not_empty && w_head_last;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench driving two reader configurations side by side
// Instance a: LATENCY=1, FIFO_DEPTH=8. Instance b: LATENCY=3, FIFO_DEPTH=4. Both see the same stimulus.
module tb_ram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          ready_fixed = 1'b1;
  logic          rand_mode = 1'b0;
  logic          rr = 1'b1;
  logic          out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_data [$];
  int            ridx [2] = '{0, 0};
  int            bidx [2] = '{0, 0};
  int            rd_cnt [2] = '{0, 0};
  int            done_cnt [2] = '{0, 0};
  logic          hold [2] = '{1'b0, 1'b0};
  logic [DW-1:0] hold_d [2];
  int            d0, d1, r0, r1;

  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];

  always #5 clk = ~clk;

  ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  assign out_ready     = rand_mode ? rr : ready_fixed;
  assign ifa.start     = start;
  assign ifa.base_addr = base_addr;
  assign ifa.length    = length;
  assign ifa.out_ready = out_ready;
  assign ifb.start     = start;
  assign ifb.base_addr = base_addr;
  assign ifb.length    = length;
  assign ifb.out_ready = out_ready;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1), .FIFO_DEPTH(8))
    u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(3), .FIFO_DEPTH(4))
    u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Synchronous RAM models: data appears LATENCY cycles after the read enable.
  always @(posedge clk) begin
    pipe_a    <= ifa.ram_read_en ? mem[ifa.ram_address] : DW'($urandom);
    pipe_b[0] <= ifb.ram_read_en ? mem[ifb.ram_address] : DW'($urandom);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ifa.ram_read_data = pipe_a;
  assign ifb.ram_read_data = pipe_b[2];

  initial forever begin
    @(posedge clk);
    #1;
    rr = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic mon(input int k, input string p, input logic rd_en, input logic [AW-1:0] addr,
                     input logic ov, input logic [DW-1:0] od, input logic ol, input logic dn);
    logic [DW:0] e;
    if (rd_en) begin
      rd_cnt[k]++;
      if (ridx[k] >= exp_addr.size()) fail_event({p, "_extra_read"});
      else begin
        check({p, "_addr"}, addr, exp_addr[ridx[k]]);
        ridx[k]++;
      end
    end
    if (hold[k]) begin
      check({p, "_hold_valid"}, ov, 1);
      check({p, "_hold_data"}, od, hold_d[k]);
    end
    if (ov && out_ready) begin
      if (bidx[k] >= exp_data.size()) fail_event({p, "_extra_beat"});
      else begin
        e = exp_data[bidx[k]];
        check({p, "_data"}, od, e[DW-1:0]);
        check({p, "_last"}, ol, e[DW]);
        check({p, "_done_on_beat"}, dn, e[DW]);
        bidx[k]++;
      end
    end
    if (dn) done_cnt[k]++;
    hold[k]   = ov && !out_ready;
    hold_d[k] = od;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        ridx[k] = exp_addr.size();
        bidx[k] = exp_data.size();
        hold[k] = 1'b0;
      end
    end else begin
      mon(0, "a", ifa.ram_read_en, ifa.ram_address, ifa.out_valid, ifa.out_data, ifa.out_last, ifa.done);
      mon(1, "b", ifb.ram_read_en, ifb.ram_address, ifb.out_valid, ifb.out_data, ifb.out_last, ifb.done);
    end
  end

  // Reference: word i of a transfer is mem[(base+i) mod 2^AW], last only on i == len-1.
  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back({i == int'(l) - 1, mem[a]});
    end
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int budget);
    int n = 0;
    while ((ifa.busy || ifb.busy || bidx[0] != exp_data.size() || bidx[1] != exp_data.size())
           && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({t, "_completes"}, n < budget, 1);
  endtask

  task automatic snap();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    r0 = rd_cnt[0];
    r1 = rd_cnt[1];
  endtask

  task automatic chk_done(input string t);
    check({t, "_a_done_count"}, done_cnt[0] - d0, 1);
    check({t, "_b_done_count"}, done_cnt[1] - d1, 1);
  endtask

  task automatic chk_reset_vals(input string t);
    check({t, "_busy"},      {ifa.busy, ifb.busy}, 0);
    check({t, "_done"},      {ifa.done, ifb.done}, 0);
    check({t, "_read_en"},   {ifa.ram_read_en, ifb.ram_read_en}, 0);
    check({t, "_address"},   {ifa.ram_address, ifb.ram_address}, 0);
    check({t, "_out_valid"}, {ifa.out_valid, ifb.out_valid}, 0);
    check({t, "_out_last"},  {ifa.out_last, ifb.out_last}, 0);
    check({t, "_out_data"},  {ifa.out_data, ifb.out_data}, 0);
    check({t, "_clken_we"},  {ifa.ram_clken, ifa.ram_write_en, ifb.ram_clken, ifb.ram_write_en}, 4'b1010);
  endtask

  initial begin
    logic [12:0] va;
    int          fvb;
    logic [AW-1:0] rb;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency and full-rate throughput with out_ready held high.
    snap();
    va  = '0;
    fvb = 0;
    start_xfer(10'h010, 11'd4);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      va[j] = ifa.out_valid;
      if (ifb.out_valid && fvb == 0) fvb = j;
    end
    check("a_valid_pattern", va, 13'h003C);
    check("b_first_valid", fvb, 4);
    wait_idle("basic", 200);
    chk_done("basic");

    // Backpressure: the credit rule caps reads at FIFO_DEPTH.
    snap();
    ready_fixed = 1'b0;
    start_xfer(AW'($urandom), 11'd16);
    repeat (20) @(posedge clk);
    #1;
    check("a_reads_while_stalled", rd_cnt[0] - r0, 8);
    check("b_reads_while_stalled", rd_cnt[1] - r1, 4);
    check("stalled_valid", {ifa.out_valid, ifb.out_valid}, 2'b11);
    check("stalled_busy", {ifa.busy, ifb.busy}, 2'b11);
    ready_fixed = 1'b1;
    wait_idle("backpressure", 300);
    chk_done("backpressure");

    // Address wrap at the top of the RAM, random out_ready.
    snap();
    rand_mode = 1'b1;
    start_xfer(10'h3FE, 11'd4);
    wait_idle("wrap", 200);
    chk_done("wrap");
    check("wrap_reads", {8'(rd_cnt[0] - r0), 8'(rd_cnt[1] - r1)}, {8'd4, 8'd4});

    // Zero length: no reads, no beats, done one cycle after the accepting edge.
    snap();
    rand_mode = 1'b0;
    start_xfer(AW'($urandom), 11'd0);
    check("zero_done_pulse", {ifa.done, ifb.done}, 2'b11);
    check("zero_busy", {ifa.busy, ifb.busy}, 2'b00);
    @(posedge clk);
    #1;
    check("zero_done_clear", {ifa.done, ifb.done}, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    check("zero_reads", {8'(rd_cnt[0] - r0), 8'(rd_cnt[1] - r1)}, 16'h0);
    chk_done("zero");

    // A start while busy is ignored.
    snap();
    rand_mode = 1'b1;
    start_xfer(AW'($urandom), 11'd6);
    repeat (3) @(posedge clk);
    #1;
    check("ignore_busy", {ifa.busy, ifb.busy}, 2'b11);
    base_addr = AW'($urandom);
    length    = 11'd9;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ignore", 300);
    repeat (10) @(posedge clk);
    #1;
    check("ignore_idle_after", {ifa.busy, ifb.busy}, 2'b00);
    chk_done("ignore");

    // Random transfers with random backpressure.
    for (int t = 0; t < 6; t++) begin
      snap();
      start_xfer(AW'($urandom), 11'($urandom_range(1, 24)));
      wait_idle("random", 400);
      chk_done("random");
    end

    // Reset in the middle of a transfer.
    rand_mode = 1'b0;
    r0 = bidx[0];
    start_xfer(AW'($urandom), 11'd10);
    fvb = 0;
    while (bidx[0] - r0 < 5 && fvb < 100) begin
      @(posedge clk);
      #1;
      fvb++;
    end
    check("reset_reached_five_beats", fvb < 100, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    snap();
    repeat (15) @(posedge clk);
    #1;
    check("post_reset_reads", {8'(rd_cnt[0] - r0), 8'(rd_cnt[1] - r1)}, 16'h0);
    check("post_reset_quiet", {ifa.busy, ifb.busy, ifa.out_valid, ifb.out_valid}, 4'h0);
    rb = AW'($urandom);
    start_xfer(rb, 11'd2);
    wait_idle("after_reset", 200);
    chk_done("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end
endmodule
